// File: rtl/uart_cmd_wrapper_if.sv
// Command/response bus between uart_cmd_wrapper (slave) and its consumer (master).
// Exposes the assembled 16-bit command and the response-byte transmit request.
interface uart_cmd_wrapper_if;
    // Handshakes: cmd is valid while cmd_rdy is high and stays valid until the
    // consumer pulses clr_cmd_rdy or a new command starts arriving. A trmt pulse
    // is accepted only while the transmitter is idle. resp is captured on that
    // pulse, and tx_done then stays low until the frame has left the TX pin.
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        trmt;
    logic [7:0]  resp;
    logic        tx_done;

    modport slave (
        output cmd, cmd_rdy, tx_done,
        input  clr_cmd_rdy, trmt, resp
    );

    modport master (
        input  cmd, cmd_rdy, tx_done,
        output clr_cmd_rdy, trmt, resp
    );
endinterface

// File: rtl/uart_cmd_wrapper.sv
// UART 8N1 receiver that assembles two-byte commands, plus an independent response transmitter.
// Optional macro UART_CMD_TIMEOUT_EN: abandon a half-received command after CMD_TIMEOUT clocks.
module uart_cmd_wrapper #(
    parameter int BAUD_DIV    = 2604,
    parameter int CMD_TIMEOUT = 1_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               RX,
    output logic               TX,
    uart_cmd_wrapper_if.slave  bus,
    output logic [0:0]         fsm_state
);

    localparam int BW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int HALF = (BAUD_DIV / 2 > 0) ? BAUD_DIV / 2 : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(HALF - 1);

    localparam logic [0:0] ST_HIGH = 1'b0;
    localparam logic [0:0] ST_LOW  = 1'b1;

    logic          rx_meta, rx_sync, rx_prev;
    logic          rx_busy, rx_first, rx_done;
    logic [BW-1:0] rx_cnt;
    logic [3:0]    rx_bits;
    logic [7:0]    rx_shift;
    logic          start_edge;

    logic [0:0]    state;
    logic [15:0]   cmd_q;
    logic          cmd_rdy_q;
    logic          timed_out;

    logic          tx_busy, tx_done_q;
    logic [BW-1:0] tx_cnt;
    logic [3:0]    tx_bits;
    logic [9:0]    tx_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = rx_prev & ~rx_sync & ~rx_busy;

    // Samples 0..8 are shifted in; the start bit falls out, leaving d7..d0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_busy  <= 1'b0;
            rx_first <= 1'b0;
            rx_done  <= 1'b0;
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
        end else begin
            rx_done <= 1'b0;
            if (start_edge) begin
                rx_busy  <= 1'b1;
                rx_first <= 1'b1;
                rx_cnt   <= '0;
                rx_bits  <= '0;
            end else if (rx_busy) begin
                if (rx_cnt == (rx_first ? HALF_LAST : BAUD_LAST)) begin
                    rx_cnt   <= '0;
                    rx_first <= 1'b0;
                    rx_bits  <= rx_bits + 4'd1;
                    if (rx_bits != 4'd9) begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                    end else begin
                        rx_busy <= 1'b0;
                        rx_done <= 1'b1;
                    end
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
            end
        end
    end

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TW = $clog2(CMD_TIMEOUT + 1);
    logic [TW-1:0] to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state != ST_LOW || rx_done) begin
            to_cnt <= '0;
        end else if (!timed_out) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timed_out = (to_cnt == TW'(CMD_TIMEOUT));
`else
    assign timed_out = 1'b0;
`endif

    // A completing low byte sets cmd_rdy even if clr_cmd_rdy arrives in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HIGH;
            cmd_q     <= 16'h0000;
            cmd_rdy_q <= 1'b0;
        end else if (rx_done) begin
            if (state == ST_HIGH) begin
                cmd_q[15:8] <= rx_shift;
                cmd_rdy_q   <= 1'b0;
                state       <= ST_LOW;
            end else begin
                cmd_q[7:0]  <= rx_shift;
                cmd_rdy_q   <= 1'b1;
                state       <= ST_HIGH;
            end
        end else begin
            if (bus.clr_cmd_rdy) begin
                cmd_rdy_q <= 1'b0;
            end
            if (state == ST_LOW && timed_out) begin
                state <= ST_HIGH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy   <= 1'b0;
            tx_done_q <= 1'b0;
            tx_cnt    <= '0;
            tx_bits   <= '0;
            tx_shift  <= '1;
        end else if (!tx_busy) begin
            if (bus.trmt) begin
                tx_shift  <= {1'b1, bus.resp, 1'b0};
                tx_busy   <= 1'b1;
                tx_done_q <= 1'b0;
                tx_cnt    <= '0;
                tx_bits   <= '0;
            end
        end else if (tx_cnt == BAUD_LAST) begin
            tx_cnt   <= '0;
            tx_shift <= {1'b1, tx_shift[9:1]};
            tx_bits  <= tx_bits + 4'd1;
            if (tx_bits == 4'd9) begin
                tx_busy   <= 1'b0;
                tx_done_q <= 1'b1;
            end
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

    assign TX          = tx_busy ? tx_shift[0] : 1'b1;
    assign bus.cmd     = cmd_q;
    assign bus.cmd_rdy = cmd_rdy_q;
    assign bus.tx_done = tx_done_q;
    assign fsm_state   = state;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Self-checking bench for uart_cmd_wrapper: command assembly, clr handshake, TX framing,
// busy-trmt rejection, full duplex, mid-frame reset and the optional timeout.
module tb_uart_cmd_wrapper;
  localparam int B    = 16;
  localparam int TO   = 400;
  localparam int HALF = B / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       tx;
  logic [0:0] fsm_state;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  uart_cmd_wrapper_if bus();

  uart_cmd_wrapper #(.BAUD_DIV(B), .CMD_TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RX        (rx),
    .TX        (tx),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at a negedge after the full frame.
  task automatic uart_send(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (B) @(negedge clk);
    end
  endtask

  task automatic cmd_monitor();
    logic prev;
    logic [15:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.cmd_rdy === 1'b1 && prev !== 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL cmd_unexpected: cmd_rdy rose with cmd=%h, required no command", bus.cmd);
        end else begin
          e = exp_q.pop_front();
          if (bus.cmd !== e) begin
            failures++;
            $display("FAIL cmd_value: cmd=%h required %h", bus.cmd, e);
          end
        end
      end
      prev = bus.cmd_rdy;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4 * B) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d commands pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    bus.clr_cmd_rdy = 1'b0;
    bus.trmt = 1'b0;
    bus.resp = 8'h00;
    repeat (3) @(negedge clk);
    checks += 5;
    if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: %b required 1", tx); end
    if (bus.cmd !== 16'h0000) begin failures++; $display("FAIL reset_cmd: %h required 0000", bus.cmd); end
    if (bus.cmd_rdy !== 1'b0) begin failures++; $display("FAIL reset_cmd_rdy: %b required 0", bus.cmd_rdy); end
    if (bus.tx_done !== 1'b0) begin failures++; $display("FAIL reset_tx_done: %b required 0", bus.tx_done); end
    if (fsm_state !== 1'b0) begin failures++; $display("FAIL reset_fsm: %b required HIGH(0)", fsm_state); end
    rst_n = 1'b1;
    repeat (2 * B) @(negedge clk);
  endtask

  task automatic test_cmd();
    int lat;
    uart_send(8'h40);
    repeat (B) @(negedge clk);
    checks += 3;
    if (bus.cmd_rdy !== 1'b0) begin failures++; $display("FAIL cmd_between_rdy: %b required 0", bus.cmd_rdy); end
    if (fsm_state !== 1'b1) begin failures++; $display("FAIL cmd_between_fsm: %b required LOW(1)", fsm_state); end
    if (bus.cmd[15:8] !== 8'h40) begin failures++; $display("FAIL cmd_high_byte: %h required 40", bus.cmd[15:8]); end
    exp_q.push_back(16'h4022);
    lat = 0;
    fork
      uart_send(8'h22);
      begin
        while (bus.cmd_rdy !== 1'b1 && lat < 12 * B) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    checks++;
    if (lat < HALF + 9 * B + 2 || lat > HALF + 9 * B + 5) begin
      failures++;
      $display("FAIL cmd_rdy_latency: %0d cycles after start edge, required %0d..%0d",
               lat, HALF + 9 * B + 2, HALF + 9 * B + 5);
    end
    wait_drain("cmd");
  endtask

  task automatic test_clr();
    int d;
    exp_q.push_back(16'h0000);
    uart_send(8'h00);
    uart_send(8'h00);
    wait_drain("clr_zero");
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    checks += 2;
    if (bus.cmd_rdy !== 1'b0) begin failures++; $display("FAIL clr_rdy: %b required 0", bus.cmd_rdy); end
    if (bus.cmd !== 16'h0000) begin failures++; $display("FAIL clr_cmd_hold: %h required 0000", bus.cmd); end
    // Learn the start-to-completion delay from the high byte, then line up clr with the low byte.
    d = 0;
    fork
      uart_send(8'h12);
      begin
        while (fsm_state === 1'b0 && d < 12 * B) begin
          @(negedge clk);
          d++;
        end
      end
    join
    checks++;
    if (fsm_state !== 1'b1 || d < 2) begin
      failures++;
      $display("FAIL clr_high_byte: fsm=%b after %0d cycles, required LOW", fsm_state, d);
    end
    exp_q.push_back(16'h1234);
    fork
      uart_send(8'h34);
      begin
        repeat (d - 1) @(negedge clk);
        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    checks += 2;
    if (bus.cmd_rdy !== 1'b1) begin failures++; $display("FAIL clr_set_wins: cmd_rdy=%b required 1", bus.cmd_rdy); end
    if (bus.cmd !== 16'h1234) begin failures++; $display("FAIL clr_set_cmd: %h required 1234", bus.cmd); end
    wait_drain("clr_set");
  endtask

  task automatic test_tx(input string name, input logic [7:0] b, input int inject_at,
                         input logic [7:0] second);
    logic [9:0] frame;
    int tx_bad, done_bad, first_bad;
    frame = {1'b1, b, 1'b0};
    tx_bad = 0;
    done_bad = 0;
    first_bad = 0;
    bus.resp = b;
    bus.trmt = 1'b1;
    @(negedge clk);
    bus.trmt = 1'b0;
    for (int k = 1; k <= 10 * B; k++) begin
      if (tx !== frame[(k - 1) / B]) begin
        if (tx_bad == 0) first_bad = k;
        tx_bad++;
      end
      if (bus.tx_done !== 1'b0) done_bad++;
      if (inject_at != 0 && k == inject_at) begin
        bus.resp = second;
        bus.trmt = 1'b1;
      end
      if (inject_at != 0 && k == inject_at + 1) bus.trmt = 1'b0;
      @(negedge clk);
    end
    checks += 3;
    if (tx_bad != 0) begin
      failures++;
      $display("FAIL %s_frame: %0d wrong TX cycles, first at cycle %0d, required frame %b lsb-first",
               name, tx_bad, first_bad, frame);
    end
    if (done_bad != 0) begin
      failures++;
      $display("FAIL %s_done_early: tx_done high on %0d cycles, required 0 before %0d", name, done_bad, 10 * B);
    end
    if (bus.tx_done !== 1'b1 || tx !== 1'b1) begin
      failures++;
      $display("FAIL %s_done_time: tx_done=%b TX=%b at cycle %0d, required 1 1", name, bus.tx_done, tx, 10 * B);
    end
    tx_bad = 0;
    for (int k = 0; k < 2 * B; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || bus.tx_done !== 1'b1) tx_bad++;
    end
    checks++;
    if (tx_bad != 0) begin
      failures++;
      $display("FAIL %s_idle: %0d cycles with TX or tx_done not 1, required 0", name, tx_bad);
    end
  endtask

  task automatic test_duplex();
    fork
      test_tx("duplex_tx", 8'h3C, 0, 8'h00);
      begin
        exp_q.push_back(16'h55AA);
        uart_send(8'h55);
        uart_send(8'hAA);
      end
    join
    wait_drain("duplex");
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] frame;
    frame = {1'b1, 8'hAB, 1'b0};
    checks++;
    if (bus.cmd_rdy !== 1'b1 || bus.cmd === 16'h0000) begin
      failures++;
      $display("FAIL rst_pre: cmd_rdy=%b cmd=%h, required 1 and nonzero", bus.cmd_rdy, bus.cmd);
    end
    bus.resp = 8'h00;
    bus.trmt = 1'b1;
    rx = frame[0];
    @(negedge clk);
    bus.trmt = 1'b0;
    repeat (B - 1) @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      rx = frame[i];
      repeat ((i < 4) ? B : HALF) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (tx !== 1'b1) begin failures++; $display("FAIL rst_async_tx: %b required 1", tx); end
    if (bus.cmd !== 16'h0000) begin failures++; $display("FAIL rst_async_cmd: %h required 0000", bus.cmd); end
    if (bus.cmd_rdy !== 1'b0) begin failures++; $display("FAIL rst_async_rdy: %b required 0", bus.cmd_rdy); end
    if (bus.tx_done !== 1'b0) begin failures++; $display("FAIL rst_async_done: %b required 0", bus.tx_done); end
    if (fsm_state !== 1'b0) begin failures++; $display("FAIL rst_async_fsm: %b required 0", fsm_state); end
    @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * B) @(negedge clk);
    checks++;
    if (fsm_state !== 1'b0 || bus.cmd_rdy !== 1'b0) begin
      failures++;
      $display("FAIL rst_release: fsm=%b cmd_rdy=%b, required 0 0", fsm_state, bus.cmd_rdy);
    end
    exp_q.push_back(16'hABCD);
    uart_send(8'hAB);
    uart_send(8'hCD);
    wait_drain("rst");
    checks++;
    if (bus.cmd !== 16'hABCD || bus.cmd_rdy !== 1'b1) begin
      failures++;
      $display("FAIL rst_after: cmd=%h rdy=%b required ABCD 1", bus.cmd, bus.cmd_rdy);
    end
  endtask

  task automatic test_timeout();
    uart_send(8'h40);
    repeat (TO + 10) @(negedge clk);
    checks++;
`ifdef UART_CMD_TIMEOUT_EN
    if (fsm_state !== 1'b0 || bus.cmd_rdy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_fsm: fsm=%b rdy=%b required HIGH(0) 0", fsm_state, bus.cmd_rdy);
    end
    exp_q.push_back(16'h8001);
`else
    if (fsm_state !== 1'b1 || bus.cmd_rdy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_fsm: fsm=%b rdy=%b required LOW(1) 0", fsm_state, bus.cmd_rdy);
    end
    exp_q.push_back(16'h4080);
`endif
    uart_send(8'h80);
    uart_send(8'h01);
    wait_drain("timeout");
  endtask

  initial begin
    fork
      cmd_monitor();
    join_none
    test_reset();
    test_cmd();
    test_clr();
    test_tx("tx_a5", 8'hA5, 0, 8'h00);
    test_tx("back_to_back", 8'hA5, 5 * B, 8'h5A);
    test_duplex();
    test_reset_mid_frame();
    test_timeout();
    repeat (B) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_cmd_wrapper.md
UART_CMD_WRAPPER -- requirements
Module: uart_cmd_wrapper

Interface
REQ-001 Parameter BAUD_DIV, default 2604, clocks per UART bit (50 MHz / 19200 baud).
REQ-002 Parameter CMD_TIMEOUT, default 1_000_000, clocks allowed between high-byte stop bit and low-byte stop bit.
REQ-003 clk  input  1  system clock; all state on rising edge; single clock domain.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 RX  input  1  serial in, 8N1, LSB first, idle high; asynchronous to clk.
REQ-006 TX  output  1  serial out, 8N1, LSB first, idle high.
REQ-007 cmd  output  16  assembled command; first received byte is cmd[15:8], second is cmd[7:0].
REQ-008 cmd_rdy  output  1  level; cmd valid and complete.
REQ-009 clr_cmd_rdy  input  1  single-cycle pulse; consumer acknowledge.
REQ-010 trmt  input  1  single-cycle pulse; start transmitting resp.
REQ-011 resp  input  8  response byte; captured on trmt.
REQ-012 tx_done  output  1  level; last transmission complete.

Function
REQ-013 RX shall be double-flopped before use; start detected on synchronized high-to-low edge while the receiver is idle.
REQ-014 Receiver: first sample at BAUD_DIV/2 after the start edge, then every BAUD_DIV clocks; 10 samples total (start, 8 data, stop); stop-bit value not checked.
REQ-015 Byte FSM states: HIGH (awaiting high byte), LOW (awaiting low byte); reset state HIGH.
REQ-016 HIGH: on byte completion, load cmd[15:8], clear cmd_rdy, go to LOW.
REQ-017 LOW: on byte completion, load cmd[7:0], set cmd_rdy on the next clock edge, go to HIGH.
REQ-018 cmd shall hold its value until overwritten by a newly received byte.
REQ-019 clr_cmd_rdy clears cmd_rdy; if clr_cmd_rdy coincides with low-byte completion, cmd_rdy is set (set wins).
REQ-020 Transmitter: on trmt while idle, capture resp, clear tx_done, send start bit, resp[0]..resp[7], stop bit; each bit lasts BAUD_DIV clocks.
REQ-021 tx_done is set exactly 10*BAUD_DIV clocks after trmt and held until the next accepted trmt.
REQ-022 trmt while a transmission is in progress is ignored; the frame in flight is unaffected.
REQ-023 Receiver and transmitter operate fully independently (full duplex).
REQ-024 Bit and baud counters are sized to hold BAUD_DIV-1 and CMD_TIMEOUT without overflow.

Reset
REQ-025 On rst_n low: TX=1, cmd=16'h0000, cmd_rdy=0, tx_done=0, FSM=HIGH, receiver and transmitter idle; takes effect immediately, with no clock required.
REQ-026 A frame in progress at reset is discarded; after release, the next detected start edge begins a new frame.

Configuration
REQ-027 Macro UART_CMD_TIMEOUT_EN.
REQ-028 If defined: a counter runs in LOW; if it reaches CMD_TIMEOUT before the low byte completes, FSM returns to HIGH, cmd_rdy stays 0, and cmd[15:8] is not reported.
REQ-029 If not defined: no timeout counter is synthesized, and LOW waits indefinitely.

Verification
REQ-030 Bytes 0x40 then 0x22 on RX -> cmd=16'h4022, cmd_rdy rises one clock after the second byte's stop sample; cmd_rdy stays low between the two bytes.
REQ-031 trmt with resp=8'hA5 -> TX low for BAUD_DIV clocks, then 1,0,1,0,0,1,0,1, then high; tx_done=1 at 10*BAUD_DIV clocks after trmt.
REQ-032 clr_cmd_rdy pulse after 0x0000 received -> cmd_rdy=0 next clock, cmd still 16'h0000; clr coincident with completion of 0x12,0x34 -> cmd_rdy=1, cmd=16'h1234.
REQ-033 Second trmt (resp=8'h5A) issued at mid-frame of 8'hA5 -> TX carries only 8'hA5, and tx_done timing is unchanged.
REQ-034 rst_n asserted during bit 4 of the high byte, then 0xAB,0xCD sent -> cmd=16'hABCD, cmd_rdy=1, and no corrupt command is reported.
REQ-035 With UART_CMD_TIMEOUT_EN, 0x40 then idle for CMD_TIMEOUT+10 clocks, then 0x80,0x01 -> cmd=16'h8001, cmd_rdy=1; without the macro the same stimulus gives cmd=16'h4080.
